// File: rtl/apb_timer_regs.sv
// Timer register bank (CTRL/LOAD/COUNT/STATUS/ID) with a prescaled 32-bit down-counter and irq.
// Latency: read data is combinational from the offset; writes and counter state update at the next clk edge.
// Backpressure: none, every strobe is accepted in the cycle it is presented.
module apb_timer_regs #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] ID_VALUE   = 32'h5449_4D01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] reg_addr_offset,
  input  logic                  reg_wr_en,
  input  logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_wdata,
  output logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  irq
);

  localparam int WW = ADDR_WIDTH - 2;

  logic          en, reload, irq_en, expired;
  logic [7:0]    prescale, pcnt;
  logic [31:0]   load, count;

  logic          en_n, reload_n, irq_en_n, expired_n;
  logic [7:0]    prescale_n, pcnt_n;
  logic [31:0]   load_n, count_n;

  logic [WW-1:0] word;
  logic          ctrl_wr, load_wr, status_wr;
  logic          tick, start, expire;

  assign word      = reg_addr_offset[ADDR_WIDTH-1:2];
  assign ctrl_wr   = reg_wr_en && (word == WW'(0));
  assign load_wr   = reg_wr_en && (word == WW'(1));
  assign status_wr = reg_wr_en && (word == WW'(3));

  assign tick   = en && (pcnt == prescale);
  assign expire = tick && (count == 32'd0);
  // Start uses the pre-edge EN so a CTRL write racing a one-shot clear does not reload.
  assign start  = ctrl_wr && reg_wdata[0] && !en;

  always_comb begin
    en_n       = en;
    reload_n   = reload;
    irq_en_n   = irq_en;
    prescale_n = prescale;
    load_n     = load;
    count_n    = count;
    expired_n  = expired;
    pcnt_n     = pcnt;

    if (expire && !reload) en_n = 1'b0;
    if (ctrl_wr) begin
      en_n       = reg_wdata[0];
      reload_n   = reg_wdata[1];
      irq_en_n   = reg_wdata[2];
      prescale_n = reg_wdata[15:8];
    end
    if (load_wr) load_n = reg_wdata;

    // Reload paths read the pre-edge LOAD, so a same-cycle LOAD write lands next time.
    if (start) begin
      count_n = load;
    end else if (tick) begin
      if (count != 32'd0) count_n = count - 32'd1;
      else if (reload)    count_n = load;
    end

    if (expire)                       expired_n = 1'b1;
    else if (status_wr && reg_wdata[0]) expired_n = 1'b0;

    if (!en_n || start || tick) pcnt_n = 8'd0;
    else                        pcnt_n = pcnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en       <= 1'b0;
      reload   <= 1'b0;
      irq_en   <= 1'b0;
      prescale <= 8'd0;
      load     <= 32'hFFFF_FFFF;
      count    <= 32'd0;
      expired  <= 1'b0;
      pcnt     <= 8'd0;
      irq      <= 1'b0;
    end else begin
      en       <= en_n;
      reload   <= reload_n;
      irq_en   <= irq_en_n;
      prescale <= prescale_n;
      load     <= load_n;
      count    <= count_n;
      expired  <= expired_n;
      pcnt     <= pcnt_n;
      irq      <= expired_n & irq_en_n;
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (word)
      WW'(0):  reg_rdata = {16'd0, prescale, 5'd0, irq_en, reload, en};
      WW'(1):  reg_rdata = load;
      WW'(2):  reg_rdata = count;
      WW'(3):  reg_rdata = {30'd0, en, expired};
      WW'(4):  reg_rdata = ID_VALUE;
      default: reg_rdata = '0;
    endcase
  end

  logic unused;
  assign unused = &{1'b0, reg_rd_en, reg_addr_offset[1:0]};

endmodule

// File: tb/tb_apb_timer_regs.sv
// Directed test of apb_timer_regs: reset map, auto-reload, one-shot, W1C races, LOAD while running, reset mid-count.
module tb_apb_timer_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] reg_addr_offset;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  apb_timer_regs dut (
    .clk             (clk),
    .rst             (rst),
    .reg_addr_offset (reg_addr_offset),
    .reg_wr_en       (reg_wr_en),
    .reg_rd_en       (reg_rd_en),
    .reg_wdata       (reg_wdata),
    .reg_rdata       (reg_rdata),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the next posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    reg_addr_offset = a;
    reg_wdata       = d;
    reg_wr_en       = 1'b1;
    step();
    reg_wr_en       = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    reg_addr_offset = a;
    reg_rd_en       = 1'b1;
    #1;
    chk(tag, reg_rdata, exp);
    reg_rd_en       = 1'b0;
  endtask

  task automatic chk_irq(input logic exp, input string tag);
    chk(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    rst = 1'b1; reg_addr_offset = '0; reg_wr_en = 1'b0; reg_rd_en = 1'b0; reg_wdata = '0;
    step(); step();
    rst = 1'b0;

    // Reset map
    rd(12'h000, 32'h0000_0000, "rst_ctrl");
    rd(12'h004, 32'hFFFF_FFFF, "rst_load");
    rd(12'h008, 32'h0000_0000, "rst_count");
    rd(12'h00C, 32'h0000_0000, "rst_status");
    rd(12'h010, 32'h5449_4D01, "rst_id");
    rd(12'h014, 32'h0000_0000, "rst_unmapped");
    rd(12'h013, 32'h5449_4D01, "id_low_bits_ignored");
    chk_irq(1'b0, "rst_irq");

    // Auto-reload, PRESCALE=0, IRQ_EN
    wr(12'h004, 32'd3);
    wr(12'h000, 32'h0000_0007);
    rd(12'h008, 32'd3, "ar_c3");
    step(); rd(12'h008, 32'd2, "ar_c2");
    step(); rd(12'h008, 32'd1, "ar_c1");
    step(); rd(12'h008, 32'd0, "ar_c0");
    chk_irq(1'b0, "ar_irq_before");
    step();
    rd(12'h008, 32'd3, "ar_reload");
    rd(12'h00C, 32'h3, "ar_status");
    chk_irq(1'b1, "ar_irq_set");
    // W1C with no expiry pending
    wr(12'h00C, 32'h1);
    rd(12'h00C, 32'h2, "w1c_clear");
    chk_irq(1'b0, "w1c_irq_fall");
    rd(12'h008, 32'd2, "w1c_c2");
    step(); rd(12'h008, 32'd1, "w1c_c1");
    step(); rd(12'h008, 32'd0, "w1c_c0");
    // W1C landing on the expiring tick: set wins
    wr(12'h00C, 32'h1);
    rd(12'h00C, 32'h3, "w1c_race");
    rd(12'h008, 32'd3, "period4_reload");
    chk_irq(1'b1, "w1c_race_irq");
    // Stop: the tick at this edge still applies, then COUNT freezes
    wr(12'h000, 32'h0);
    rd(12'h008, 32'd2, "stop_count");
    step(); step(); step();
    rd(12'h008, 32'd2, "stop_frozen");
    rd(12'h00C, 32'h1, "stop_status");
    chk_irq(1'b0, "stop_irq_en_clear");

    // One-shot, PRESCALE=1
    wr(12'h00C, 32'h1);
    wr(12'h004, 32'd2);
    wr(12'h000, 32'h0000_0105);
    rd(12'h008, 32'd2, "os_e0");
    step(); rd(12'h008, 32'd2, "os_e1_hold");
    step(); rd(12'h008, 32'd1, "os_e2");
    step(); step(); rd(12'h008, 32'd0, "os_e4");
    chk_irq(1'b0, "os_irq_before");
    step(); step();
    rd(12'h000, 32'h0000_0104, "os_en_cleared");
    rd(12'h00C, 32'h1, "os_status");
    rd(12'h008, 32'd0, "os_count0");
    chk_irq(1'b1, "os_irq");
    step(); step();
    rd(12'h008, 32'd0, "os_hold0");

    // LOAD write while running
    wr(12'h00C, 32'h1);
    wr(12'h004, 32'd6);
    wr(12'h000, 32'h0000_0003);
    rd(12'h008, 32'd6, "ld_c6");
    step(); rd(12'h008, 32'd5, "ld_c5");
    wr(12'h004, 32'd10);
    rd(12'h008, 32'd4, "ld_c4");
    rd(12'h004, 32'd10, "ld_load10");
    step(); rd(12'h008, 32'd3, "ld_c3");
    step(); step(); step();
    rd(12'h008, 32'd0, "ld_c0");
    step();
    rd(12'h008, 32'd10, "ld_reload10");
    wr(12'h000, 32'h0000_0002);
    rd(12'h008, 32'd9, "ld_stop");
    step(); step();
    rd(12'h008, 32'd9, "ld_frozen");
    wr(12'h000, 32'h0000_0003);
    rd(12'h008, 32'd10, "ld_restart");

    // EN 1->1 write: no reload, enables irq
    wr(12'h000, 32'h0000_0007);
    rd(12'h008, 32'd9, "en11_noreload");
    chk_irq(1'b1, "en11_irq");
    step(); step();
    rd(12'h008, 32'd7, "pre_rst_c7");

    // Reset mid-count
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_irq(1'b0, "mid_rst_irq");
    rd(12'h000, 32'h0, "mid_rst_ctrl");
    rd(12'h004, 32'hFFFF_FFFF, "mid_rst_load");
    rd(12'h008, 32'h0, "mid_rst_count");
    rd(12'h00C, 32'h0, "mid_rst_status");
    step(); step();
    rd(12'h008, 32'h0, "no_residual_tick");
    wr(12'h008, 32'h1234_5678);
    rd(12'h008, 32'h0, "count_ro");
    wr(12'h014, 32'hDEAD_BEEF);
    rd(12'h014, 32'h0, "unmapped_wr");
    rd(12'h000, 32'h0, "unmapped_no_alias");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
